// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32 pipeline hazard controller.
package hazard_pkg;

    // Operand source selects driven onto ForwardAE/ForwardBE
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // ResultSrcE encoding that marks a load in E
    localparam logic [1:0] RESULT_LOAD = 2'b01;

    // Multi-cycle EX unit occupancy states
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_t;

    // Pipeline register enable/flush bundle produced by the priority logic
    typedef struct packed {
        logic stallF;
        logic stallD;
        logic stallE;
        logic flushD;
        logic flushE;
        logic flushM;
    } hz_ctl_t;

endpackage : hazard_pkg

// File: rtl/mc_stall_fsm.sv
// Occupancy tracker for variable-latency mul/div ops in E: an op of latency N
// keeps E busy for N cycles and requests N-1 stall cycles.
module mc_stall_fsm
    import hazard_pkg::*;
#(
    parameter int unsigned MC_LAT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mcStartE,
    input  logic [MC_LAT_W-1:0] mcLatE,
    output logic                mcStall,
    output logic                mcBusy,
    output logic                mcDone
);

    localparam logic [MC_LAT_W-1:0] LAT_ONE = MC_LAT_W'(1);

    mc_state_t           state;
    logic [MC_LAT_W-1:0] cnt;
    logic                startLong;

    // Latency 0 and 1 complete in a single E cycle, so only longer ops start the FSM
    assign startLong = (state == IDLE) && mcStartE && (mcLatE > LAT_ONE);

    // State register and remaining-cycle down-counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (startLong) begin
                        state <= BUSY;
                        cnt   <= mcLatE - LAT_ONE;
                    end
                end
                BUSY: begin
                    if (cnt <= LAT_ONE) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - LAT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Stall covers the issue cycle plus every BUSY cycle except the last
    assign mcStall = startLong || ((state == BUSY) && (cnt > LAT_ONE));
    assign mcBusy  = (state == BUSY);
    assign mcDone  = (state == BUSY) && (cnt == LAT_ONE);

endmodule : mc_stall_fsm

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller: M/W forwarding, load-use and RAW stalls,
// branch flush, multi-cycle EX stall and saturating stall/flush counters.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned MC_LAT_W = 6,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned FWD_EN   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_AW-1:0]   rs1D,
    input  logic [REG_AW-1:0]   rs2D,
    input  logic                rs1UsedD,
    input  logic                rs2UsedD,
    input  logic [REG_AW-1:0]   rs1E,
    input  logic [REG_AW-1:0]   rs2E,
    input  logic [REG_AW-1:0]   rdE,
    input  logic                RegWriteE,
    input  logic [1:0]          ResultSrcE,
    input  logic                PCSrcE,
    input  logic                mcStartE,
    input  logic [MC_LAT_W-1:0] mcLatE,
    input  logic [REG_AW-1:0]   rdM,
    input  logic [REG_AW-1:0]   rdW,
    input  logic                RegWriteM,
    input  logic                RegWriteW,
    input  logic                cntClr,
    output logic                StallF,
    output logic                StallD,
    output logic                StallE,
    output logic                FlushD,
    output logic                FlushE,
    output logic                FlushM,
    output logic [1:0]          ForwardAE,
    output logic [1:0]          ForwardBE,
    output logic                mcBusy,
    output logic                mcDone,
    output logic [CNT_W-1:0]    stallCnt,
    output logic [CNT_W-1:0]    flushCnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fwd_sel_t fwdA;
    fwd_sel_t fwdB;
    logic     lwStall;
    logic     rawStall;
    logic     mcStall;
    hz_ctl_t  ctl;

    // A source is satisfied by a writer that targets it and is not x0
    function automatic logic writes(input logic [REG_AW-1:0] rs,
                                    input logic [REG_AW-1:0] rd,
                                    input logic              we);
        return we && (rd != '0) && (rd == rs);
    endfunction

    // Forward select for one E operand, M newer than W
    function automatic fwd_sel_t fwdSel(input logic [REG_AW-1:0] rs);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (FWD_EN != 0) begin
            if (writes(rs, rdM, RegWriteM)) begin
                sel = FWD_MEM;
            end else if (writes(rs, rdW, RegWriteW)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    // D source reads a value still in flight somewhere in E/M/W
    function automatic logic rawHit(input logic [REG_AW-1:0] rs, input logic used);
        return used && (writes(rs, rdE, RegWriteE) ||
                        writes(rs, rdM, RegWriteM) ||
                        writes(rs, rdW, RegWriteW));
    endfunction

    // Operand forwarding selects for E
    always_comb begin
        fwdA = fwdSel(rs1E);
        fwdB = fwdSel(rs2E);
    end

    assign ForwardAE = fwdA;
    assign ForwardBE = fwdB;

    // Load in E feeding a D-stage source must wait one cycle for memory data
    always_comb begin
        lwStall = (ResultSrcE == RESULT_LOAD) && (rdE != '0) &&
                  ((rs1UsedD && (rs1D == rdE)) || (rs2UsedD && (rs2D == rdE)));
    end

    // Without a bypass network every in-flight RAW dependency stalls in D
    always_comb begin
        rawStall = 1'b0;
        if (FWD_EN == 0) begin
            rawStall = rawHit(rs1D, rs1UsedD) || rawHit(rs2D, rs2UsedD);
        end
    end

    mc_stall_fsm #(
        .MC_LAT_W (MC_LAT_W)
    ) u_mc_stall_fsm (
        .clk      (clk),
        .reset    (reset),
        .mcStartE (mcStartE),
        .mcLatE   (mcLatE),
        .mcStall  (mcStall),
        .mcBusy   (mcBusy),
        .mcDone   (mcDone)
    );

    // Prioritised stall/flush: multi-cycle hold, then branch redirect, then data hazard
    always_comb begin
        ctl = '0;
        if (mcStall) begin
            ctl.stallF = 1'b1;
            ctl.stallD = 1'b1;
            ctl.stallE = 1'b1;
            ctl.flushM = 1'b1;
        end else if (PCSrcE) begin
            // Dependent instruction in D is squashed, so no load-use stall needed
            ctl.flushD = 1'b1;
            ctl.flushE = 1'b1;
        end else if (lwStall || rawStall) begin
            ctl.stallF = 1'b1;
            ctl.stallD = 1'b1;
            ctl.flushE = 1'b1;
        end
    end

    assign StallF = ctl.stallF;
    assign StallD = ctl.stallD;
    assign StallE = ctl.stallE;
    assign FlushD = ctl.flushD;
    assign FlushE = ctl.flushE;
    assign FlushM = ctl.flushM;

    // Saturating count of fetch-stall cycles; clear wins over increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCnt <= '0;
        end else if (cntClr) begin
            stallCnt <= '0;
        end else if (ctl.stallF && (stallCnt != CNT_MAX)) begin
            stallCnt <= stallCnt + CNT_ONE;
        end
    end

    // Saturating count of cycles flushing any pipeline register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flushCnt <= '0;
        end else if (cntClr) begin
            flushCnt <= '0;
        end else if ((ctl.flushD || ctl.flushE || ctl.flushM) && (flushCnt != CNT_MAX)) begin
            flushCnt <= flushCnt + CNT_ONE;
        end
    end

endmodule : hazard_ctrl_mc

// File: tb/tb_hazard_ctrl_mc.sv
// Directed scoreboard bench for hazard_ctrl_mc: default build, a 4-bit counter
// build and a no-forwarding build, all driven from the same stimulus.
module tb_hazard_ctrl_mc;

    // Expected-vector layout: {StallF,StallD,StallE,FlushD,FlushE,FlushM,FwdA[1:0],FwdB[1:0],mcBusy,mcDone}
    localparam logic [11:0] Z    = 12'h000;
    localparam logic [11:0] LW   = 12'hC80;
    localparam logic [11:0] BR   = 12'h180;
    localparam logic [11:0] MC   = 12'hE40;
    localparam logic [11:0] BSY  = 12'h002;
    localparam logic [11:0] DONE = 12'h001;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       rs1UsedD, rs2UsedD, RegWriteE, RegWriteM, RegWriteW, PCSrcE, mcStartE, cntClr;
    logic [1:0] ResultSrcE;
    logic [5:0] mcLatE;

    logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, mcBusy, mcDone;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] stallCnt, flushCnt;
    logic        StallF4, StallD4, StallE4, FlushD4, FlushE4, FlushM4, mcBusy4, mcDone4;
    logic [1:0]  ForwardAE4, ForwardBE4;
    logic [3:0]  stallCnt4, flushCnt4;
    logic        StallFn, StallDn, StallEn, FlushDn, FlushEn, FlushMn, mcBusyn, mcDonen;
    logic [1:0]  ForwardAEn, ForwardBEn;
    logic [15:0] stallCntn, flushCntn;

    logic [11:0] obsMain, obs4, obsNf;

    typedef struct {
        string       tag;
        logic [11:0] e;
        logic [11:0] eNf;
    } sbEntry_t;

    sbEntry_t    sb[$];
    int unsigned mS[3];
    int unsigned mF[3];
    int unsigned cMax[3];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl_mc dut (
        .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1UsedD(rs1UsedD), .rs2UsedD(rs2UsedD),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
        .PCSrcE(PCSrcE), .mcStartE(mcStartE), .mcLatE(mcLatE), .rdM(rdM), .rdW(rdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .cntClr(cntClr),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE),
        .FlushM(FlushM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mcBusy(mcBusy),
        .mcDone(mcDone), .stallCnt(stallCnt), .flushCnt(flushCnt)
    );

    hazard_ctrl_mc #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1UsedD(rs1UsedD), .rs2UsedD(rs2UsedD),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
        .PCSrcE(PCSrcE), .mcStartE(mcStartE), .mcLatE(mcLatE), .rdM(rdM), .rdW(rdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .cntClr(cntClr),
        .StallF(StallF4), .StallD(StallD4), .StallE(StallE4), .FlushD(FlushD4), .FlushE(FlushE4),
        .FlushM(FlushM4), .ForwardAE(ForwardAE4), .ForwardBE(ForwardBE4), .mcBusy(mcBusy4),
        .mcDone(mcDone4), .stallCnt(stallCnt4), .flushCnt(flushCnt4)
    );

    hazard_ctrl_mc #(.FWD_EN(0)) dutNf (
        .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1UsedD(rs1UsedD), .rs2UsedD(rs2UsedD),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
        .PCSrcE(PCSrcE), .mcStartE(mcStartE), .mcLatE(mcLatE), .rdM(rdM), .rdW(rdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .cntClr(cntClr),
        .StallF(StallFn), .StallD(StallDn), .StallE(StallEn), .FlushD(FlushDn), .FlushE(FlushEn),
        .FlushM(FlushMn), .ForwardAE(ForwardAEn), .ForwardBE(ForwardBEn), .mcBusy(mcBusyn),
        .mcDone(mcDonen), .stallCnt(stallCntn), .flushCnt(flushCntn)
    );

    assign obsMain = {StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE, mcBusy, mcDone};
    assign obs4    = {StallF4, StallD4, StallE4, FlushD4, FlushE4, FlushM4, ForwardAE4, ForwardBE4, mcBusy4, mcDone4};
    assign obsNf   = {StallFn, StallDn, StallEn, FlushDn, FlushEn, FlushMn, ForwardAEn, ForwardBEn, mcBusyn, mcDonen};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // No-forwarding build behaves identically apart from the forward selects
    function automatic logic [11:0] nf(input logic [11:0] e);
        return e & ~12'h03C;
    endfunction

    task automatic idleInputs();
        rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
        rs1UsedD = 1'b0; rs2UsedD = 1'b0; RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        ResultSrcE = 2'b00; PCSrcE = 1'b0; mcStartE = 1'b0; mcLatE = '0; cntClr = 1'b0;
    endtask

    // Queue expectation for the cycle just driven, then compare at the falling edge
    task automatic step(input string tag, input logic [11:0] e, input logic [11:0] eNf);
        sbEntry_t s;
        sb.push_back('{tag, e, eNf});
        @(negedge clk);
        s = sb.pop_front();
        chk({s.tag, " ctl"}, 32'(obsMain), 32'(s.e));
        chk({s.tag, " ctl4"}, 32'(obs4), 32'(s.e));
        chk({s.tag, " ctlNf"}, 32'(obsNf), 32'(s.eNf));
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                mS[i] = 0;
                mF[i] = 0;
            end
        end
        chk({s.tag, " stallCnt"}, 32'(stallCnt), mS[0]);
        chk({s.tag, " flushCnt"}, 32'(flushCnt), mF[0]);
        chk({s.tag, " stallCnt4"}, 32'(stallCnt4), mS[1]);
        chk({s.tag, " flushCnt4"}, 32'(flushCnt4), mF[1]);
        chk({s.tag, " stallCntNf"}, 32'(stallCntn), mS[2]);
        chk({s.tag, " flushCntNf"}, 32'(flushCntn), mF[2]);
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                logic [11:0] ev;
                ev = (i == 2) ? s.eNf : s.e;
                if (cntClr) begin
                    mS[i] = 0;
                    mF[i] = 0;
                end else begin
                    if (ev[11] && mS[i] < cMax[i]) mS[i]++;
                    if ((ev[8] || ev[7] || ev[6]) && mF[i] < cMax[i]) mF[i]++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        cMax[0] = 65535; cMax[1] = 15; cMax[2] = 65535;
        for (int i = 0; i < 3; i++) begin
            mS[i] = 0;
            mF[i] = 0;
        end
        idleInputs();
        reset = 1'b0;
        step("reset", Z, Z);
        reset = 1'b1;
        step("post-reset idle", Z, Z);

        // Forwarding priority
        rdM = 5'd5; rdW = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1; rs1E = 5'd5;
        step("fwdA mem", 12'h020, Z);
        rs2E = 5'd5;
        step("fwdA/B mem", 12'h028, Z);
        RegWriteM = 1'b0;
        step("fwdA/B wb", 12'h014, Z);
        rdM = 5'd0; rdW = 5'd0; RegWriteM = 1'b1;
        step("fwd x0", Z, Z);
        idleInputs();

        // Load-use for exactly one cycle
        ResultSrcE = 2'b01; rdE = 5'd7; RegWriteE = 1'b1; rs2D = 5'd7; rs2UsedD = 1'b1;
        step("load-use", LW, LW);
        idleInputs();
        step("load-use bubble", Z, Z);
        ResultSrcE = 2'b01; rdE = 5'd7; RegWriteE = 1'b1; rs2D = 5'd7; rs2UsedD = 1'b0;
        step("load unused src", Z, Z);
        rs2UsedD = 1'b1; PCSrcE = 1'b1;
        step("load-use + branch", BR, BR);
        idleInputs();

        // RAW stalls only without forwarding
        rdM = 5'd3; RegWriteM = 1'b1; rs1D = 5'd3; rs1UsedD = 1'b1;
        step("raw M", Z, LW);
        idleInputs();
        rdW = 5'd4; RegWriteW = 1'b1; rs2D = 5'd4; rs2UsedD = 1'b1;
        step("raw W", Z, LW);
        idleInputs();
        rdE = 5'd6; RegWriteE = 1'b1; rs1D = 5'd6; rs1UsedD = 1'b1;
        step("raw E alu", Z, LW);
        idleInputs();

        // Latency-4 multi-cycle op
        mcStartE = 1'b1; mcLatE = 6'd4;
        step("mc4 c0", MC, MC);
        step("mc4 c1", MC | BSY, MC | BSY);
        step("mc4 c2", MC | BSY, MC | BSY);
        step("mc4 c3", BSY | DONE, BSY | DONE);
        idleInputs();
        step("mc4 after", Z, Z);
        mcStartE = 1'b1; mcLatE = 6'd1;
        step("mc lat1", Z, Z);
        mcLatE = 6'd0;
        step("mc lat0", Z, Z);
        idleInputs();
        step("mc short after", Z, Z);

        // Reset aborting a latency-10 op
        mcStartE = 1'b1; mcLatE = 6'd10;
        step("mc10 c0", MC, MC);
        step("mc10 c1", MC | BSY, MC | BSY);
        idleInputs();
        reset = 1'b0;
        step("mc10 reset", Z, Z);
        step("mc10 reset hold", Z, Z);
        reset = 1'b1;
        mcStartE = 1'b1; mcLatE = 6'd3;
        step("mc3 c0", MC, MC);
        step("mc3 c1", MC | BSY, MC | BSY);
        step("mc3 c2", BSY | DONE, BSY | DONE);
        idleInputs();
        step("mc3 after", Z, Z);

        // Counter saturation and clear
        ResultSrcE = 2'b01; rdE = 5'd7; RegWriteE = 1'b1; rs2D = 5'd7; rs2UsedD = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step($sformatf("sat stall %0d", n), LW, LW);
        end
        cntClr = 1'b1;
        step("clr with stall", LW, LW);
        idleInputs();
        step("after clr", Z, Z);
        step("final idle", Z, Z);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hazard_ctrl_mc
